// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   fetch_entry_t  : one prefetched instruction and the address it came from
//   fetch_state_e  : fetch control states
//   FETCH_RESET_PC : default first fetch address after reset
//   align_pc()     : clears the byte-offset bits of a fetch address
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // Instruction fetches are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: prefetch queue of fetch_entry_t records.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write din at the tail (ignored when full without a pop)
//   pop         : drop the head (ignored when empty)
//   flush       : empty the queue; takes priority over push/pop
//   head        : entry at the head, read straight from storage registers
//   count       : number of valid entries
//   nonempty    : registered (count != 0)
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_entry_t     din,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             nonempty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Qualify requests so the pointers can never overrun each other.
  always_comb begin
    full    = (cnt_q == CNT_W'(DEPTH));
    pop_ok  = pop && (cnt_q != '0);
    push_ok = push && (!full || pop_ok);
    cnt_d   = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push_ok && !pop_ok) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Storage and pointers; storage is cleared on reset so head reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt_q    <= '0;
      nonempty <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      nonempty <= (cnt_d != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) begin
          mem[wr_ptr] <= din;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: sequential instruction prefetcher feeding a valid/ready
// consumer through a small queue.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   imem_addr / imem_rd     : word-aligned fetch address, same-cycle read data
//   redirect_valid/_pc      : one-cycle restart of fetch at a new address
//   instr_valid/_ready      : head handshake toward the consumer
//   instr / instr_pc        : head instruction word and its address
//   fetch_fault             : misaligned-redirect indication, only present
//                             when FETCH_MISALIGN_CHECK_EN is defined
// Parameters: RESET_PC (first fetch address), DEPTH (queue entries, 2..16,
// power of two).
// Build option: FETCH_MISALIGN_CHECK_EN enables the FAULT state.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_FETCH = FETCH;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [0:0] ST_FAULT = FAULT;
`endif

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [31:0]      fetch_pc_q;
  logic [31:0]      fetch_pc_d;
  logic             push;
  logic             pop;
  logic             flush;
  logic             pop_req;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;
  logic             nonempty;

  // Control: redirect beats everything; otherwise fetch whenever a slot
  // is free now or is being freed by this cycle's pop.
  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    push             = 1'b0;
    pop              = 1'b0;
    flush            = 1'b0;
    pop_req          = nonempty && instr_ready;
    push_entry.pc    = fetch_pc_q;
    push_entry.instr = imem_rd;
    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = align_pc(redirect_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
          if (redirect_pc[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end
`endif
        end else begin
          pop  = pop_req;
          push = (count < CNT_W'(DEPTH)) || pop_req;
          if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: begin
        // Parked with an empty queue until an aligned redirect arrives.
        if (redirect_valid) begin
          flush      = 1'b1;
          fetch_pc_d = align_pc(redirect_pc);
          if (redirect_pc[1:0] == 2'b00) begin
            state_d = ST_FETCH;
          end
        end
      end
`endif
      default: begin
        state_d = ST_FETCH;
        flush   = 1'b1;
      end
    endcase
  end

  // State and fetch address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      (push_entry),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count),
    .nonempty (nonempty)
  );

  assign imem_addr   = fetch_pc_q;
  assign instr_valid = nonempty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = (state_q == ST_FAULT);
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl (DEPTH=4, RESET_PC=0): a directed
// vector table, a scoreboard of the expected instruction stream popped on
// every consumer handshake, and hand-written redirect/reset sequences.
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int checks = 0;
  int errors = 0;
  bit sb_on  = 1'b0;
  fetch_entry_t sb [$];

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   rom = 32'h0140_0093;
      32'h4:   rom = 32'h0050_0113;
      32'h8:   rom = 32'h0220_d1b3;
      default: rom = {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_rd = rom(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_stream(input logic [31:0] pc, input int n);
    fetch_entry_t e;
    sb.delete();
    for (int i = 0; i < n; i++) begin
      e.pc    = pc + 32'(4 * i);
      e.instr = rom(e.pc);
      sb.push_back(e);
    end
  endtask

  // Every accepted head must be the next word of the expected stream.
  always @(negedge clk) begin
    fetch_entry_t e;
    #1;
    if (sb_on && rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got pc %h with empty scoreboard", instr_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.instr);
      end
    end
  end

  task automatic do_reset();
    rst_n          = 1'b0;
    sb_on          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // rdy rv rpc -> expected valid, head pc, imem_addr after the next edge
    vt[0]  = mk(1, 0, 32'h0,  1, 32'h0,  32'h04);
    vt[1]  = mk(1, 0, 32'h0,  1, 32'h4,  32'h08);
    vt[2]  = mk(1, 0, 32'h0,  1, 32'h8,  32'h0C);
    vt[3]  = mk(0, 0, 32'h0,  1, 32'h8,  32'h10);
    vt[4]  = mk(0, 0, 32'h0,  1, 32'h8,  32'h14);
    vt[5]  = mk(0, 0, 32'h0,  1, 32'h8,  32'h18);
    vt[6]  = mk(0, 0, 32'h0,  1, 32'h8,  32'h18);
    vt[7]  = mk(1, 0, 32'h0,  1, 32'hC,  32'h1C);
    vt[8]  = mk(1, 0, 32'h0,  1, 32'h10, 32'h20);
    vt[9]  = mk(1, 1, 32'h10, 0, 32'h0,  32'h10);
    vt[10] = mk(1, 0, 32'h0,  1, 32'h10, 32'h14);
    vt[11] = mk(1, 0, 32'h0,  1, 32'h14, 32'h18);
    vt[12] = mk(1, 1, 32'h13, 0, 32'h0,  32'h10);
`ifdef FETCH_MISALIGN_CHECK_EN
    vt[13] = mk(1, 0, 32'h0,  0, 32'h0,  32'h10);
`else
    vt[13] = mk(1, 0, 32'h0,  1, 32'h10, 32'h14);
`endif

    // Reset state.
    #1;
    chk("rst_valid_in_reset", 32'(instr_valid), 32'h0);
    do_reset();
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_fault", 32'(fetch_fault), 32'h0);
`endif

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      instr_ready    = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_pc", i), instr_pc, vt[i].epc);
        chk($sformatf("vec%0d_instr", i), instr, rom(vt[i].epc));
      end
      chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].eaddr);
    end
    redirect_valid = 1'b0;

    // Stall from reset until full, then stream at one word per cycle.
    do_reset();
    start_stream(32'h0, 40);
    sb_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_pc", instr_pc, 32'h0);
    end
    chk("stall_instr", instr, 32'h0140_0093);
    chk("stall_addr", imem_addr, 32'h10);
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("full_stream_addr", imem_addr, 32'h10 + 32'(4 * (i + 1)));
    end
    instr_ready = 1'b0;
    sb_on = 1'b0;

    // Redirect with three entries queued.
    do_reset();
    repeat (3) @(negedge clk);
    chk("q3_pc", instr_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    chk("redir_valid_gap", 32'(instr_valid), 32'h0);
    @(negedge clk);
    chk("redir_valid", 32'(instr_valid), 32'h1);
    chk("redir_pc", instr_pc, 32'h10);
    chk("redir_instr", instr, rom(32'h10));

    // Misaligned redirect.
    do_reset();
    instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h12;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis_valid_gap", 32'(instr_valid), 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault", 32'(fetch_fault), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mis_fault_hold_valid", 32'(instr_valid), 32'h0);
      chk("mis_fault_hold", 32'(fetch_fault), 32'h1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("mis_fault_clear", 32'(fetch_fault), 32'h0);
    chk("mis_recover_gap", 32'(instr_valid), 32'h0);
    @(negedge clk);
    chk("mis_recover_valid", 32'(instr_valid), 32'h1);
    chk("mis_recover_pc", instr_pc, 32'h0);
`else
    @(negedge clk);
    chk("mis_valid", 32'(instr_valid), 32'h1);
    chk("mis_pc", instr_pc, 32'h10);
`endif

    // Address wrap through 2^32.
    do_reset();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    start_stream(32'hFFFF_FFF8, 20);
    sb_on = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("wrap_sb_drained", 32'(sb.size()), 32'd15);
    sb_on = 1'b0;
    instr_ready = 1'b0;

    // Reset asserted mid-stream with two entries queued.
    do_reset();
    repeat (2) @(negedge clk);
    chk("mid_q2_valid", 32'(instr_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_valid", 32'(instr_valid), 32'h1);
    chk("mid_rel_pc", instr_pc, 32'h0);
    chk("mid_rel_instr", instr, 32'h0140_0093);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: prefetch queue entries, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr  output  32  byte address to instruction memory, word-aligned.
REQ-006 SHALL have port imem_rd  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  one-cycle request to restart fetch.
REQ-008 SHALL have port redirect_pc  input  32  new fetch address.
REQ-009 SHALL have port instr_valid  output  1  queue head valid.
REQ-010 SHALL have port instr_ready  input  1  consumer accepts the head when high with instr_valid.
REQ-011 SHALL have port instr  output  32  head instruction word.
REQ-012 SHALL have port instr_pc  output  32  address of the head instruction.

Function
REQ-013 SHALL hold fetch_pc and drive imem_addr = fetch_pc continuously.
REQ-014 SHALL push {fetch_pc, imem_rd} into the queue, then advance fetch_pc by 4, in every cycle where count < DEPTH, or a pop occurs in that cycle, and no redirect is present.
REQ-015 SHALL pop the head when instr_valid && instr_ready; instr_valid SHALL equal (count != 0).
REQ-016 SHALL drive instr and instr_pc from registered queue storage, not from imem_rd; fetch-to-output latency is exactly 1 cycle.
REQ-017 SHALL allow simultaneous push and pop when full, leaving count unchanged.
REQ-018 SHALL on redirect_valid: flush the queue (count := 0), set fetch_pc := {redirect_pc[31:2], 2'b00}, suppress that cycle's push and pop; redirect wins over all other events.
REQ-019 SHALL deassert instr_valid in the cycle after a redirect; first redirected instruction is valid 2 cycles after redirect_valid.
REQ-020 SHALL wrap fetch_pc modulo 2^32 (32'hFFFF_FFFC + 4 = 0) with no flag.
REQ-021 SHALL implement control FSM states FETCH and FAULT; FAULT exists only under REQ-026.
REQ-022 SHALL keep instr/instr_pc stable while instr_valid && !instr_ready.

Reset
REQ-023 SHALL on rst_n low, asynchronously: fetch_pc := RESET_PC, count := 0, read/write pointers := 0, state := FETCH, instr_valid := 0.
REQ-024 SHALL reset instr and instr_pc to 0; fetch_fault (if present) to 0.
REQ-025 SHALL, on reset mid-operation, discard all queued entries; first fetch after release is at RESET_PC.

Configuration
REQ-026 SHALL, with FETCH_MISALIGN_CHECK_EN defined, add output fetch_fault (1 bit); a redirect with redirect_pc[1:0] != 0 enters FAULT: queue flushed, no pushes, fetch_fault = 1, until an aligned redirect returns to FETCH.
REQ-027 SHALL, without FETCH_MISALIGN_CHECK_EN, omit fetch_fault and the FAULT state; redirect_pc[1:0] silently cleared.

Structure
REQ-028 SHALL place fetch_entry_t (struct: pc[31:0], instr[31:0]), the fetch state enum and the default RESET_PC in shared package fetch_pkg.
REQ-029 SHALL implement the queue as sub-module fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, count output).

Verification
REQ-030 SHALL cover reset release with ROM = {01400093, 00500113, 0220d1b3}, instr_ready=1 -> cycle 1: instr=01400093, instr_pc=0; cycle 2: 00500113, pc 4; cycle 3: 0220d1b3, pc 8.
REQ-031 SHALL cover instr_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4, fetch_pc=16, head stays 01400093/pc 0.
REQ-032 SHALL cover full queue with instr_ready=1 -> one push and one pop per cycle, count stays 4.
REQ-033 SHALL cover redirect_pc=32'h10 while queue holds 3 entries -> next cycle instr_valid=0; following cycle instr_pc=32'h10, instr=ROM[4].
REQ-034 SHALL cover redirect_pc=32'h12 -> with macro: fetch_fault=1, instr_valid stays 0 until redirect 32'h0; without macro: instr_pc=32'h10 after 2 cycles.
REQ-035 SHALL cover rst_n asserted mid-stream with 2 entries queued -> instr_valid=0 immediately; after release, instr_pc=RESET_PC.
